// File: rtl/icache_pkg.sv
// Shared constants for the direct-mapped instruction cache: FSM state codes and the
// instruction value presented while no valid word is available.
package icache_pkg;

   localparam logic        ICACHE_IDLE = 1'b0;
   localparam logic        ICACHE_FILL = 1'b1;
   localparam logic [15:0] ICACHE_NOP  = 16'h0000;

endpackage

// File: rtl/icache_array.sv
// Tag/valid/data storage for icache: combinational read by index, single write port.
// Latency 0 on read, write takes effect on the next rising edge; only valid bits are reset.
module icache_array
   import icache_pkg::*;
#(
   parameter int SETS       = 8,
   parameter int LINE_WORDS = 4,
   parameter int IDX_W      = 3,
   parameter int TAG_W      = 11
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [IDX_W-1:0]        ridx,
   output logic                    rvalid,
   output logic [TAG_W-1:0]        rtag,
   output logic [16*LINE_WORDS-1:0] rline,
   input  logic                    we,
   input  logic [IDX_W-1:0]        widx,
   input  logic [TAG_W-1:0]        wtag,
   input  logic [16*LINE_WORDS-1:0] wline
);

   logic [SETS-1:0]             valid;
   logic [TAG_W-1:0]            tag_mem  [SETS];
   logic [16*LINE_WORDS-1:0]    data_mem [SETS];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid <= '0;
      end else if (we) begin
         valid[widx] <= 1'b1;
      end
   end

   // Tag and data contents are don't-care until the matching valid bit is set.
   always_ff @(posedge clk) begin
      if (we) begin
         tag_mem[widx]  <= wtag;
         data_mem[widx] <= wline;
      end
   end

   assign rvalid = valid[ridx];
   assign rtag   = tag_mem[ridx];
   assign rline  = data_mem[ridx];

endmodule

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache: 0-cycle hits, i_rdy held low while a line fill runs.
// Optional hit/miss counters when ICACHE_PERF_CNT_EN is defined.
module icache
   import icache_pkg::*;
#(
   parameter int SETS       = 8,
   parameter int LINE_WORDS = 4,
   parameter int ADDR_W     = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [ADDR_W-1:0]        i_addr,
   output logic [15:0]              instr,
   output logic                     i_rdy,
   output logic                     mem_req,
   output logic [ADDR_W-1:0]        mem_addr,
   input  logic                     mem_rdy,
   input  logic [16*LINE_WORDS-1:0] mem_line
`ifdef ICACHE_PERF_CNT_EN
   ,
   output logic [15:0]              hit_cnt,
   output logic [15:0]              miss_cnt
`endif
);

   localparam int OFF_W = $clog2(LINE_WORDS);
   localparam int IDX_W = $clog2(SETS);
   localparam int TAG_W = ADDR_W - OFF_W - IDX_W;

   logic                      state;
   logic [ADDR_W-1:0]         miss_addr;
   logic [OFF_W-1:0]          off;
   logic [IDX_W-1:0]          idx;
   logic [TAG_W-1:0]          tag;
   logic                      rvalid;
   logic [TAG_W-1:0]          rtag;
   logic [16*LINE_WORDS-1:0]  rline;
   logic                      hit;
   logic                      fill_done;

   assign off = i_addr[OFF_W-1:0];
   assign idx = i_addr[OFF_W+IDX_W-1:OFF_W];
   assign tag = i_addr[ADDR_W-1:OFF_W+IDX_W];

   assign hit       = rvalid && (rtag == tag) && (state == ICACHE_IDLE);
   assign fill_done = (state == ICACHE_FILL) && mem_rdy;

   icache_array #(
      .SETS       (SETS),
      .LINE_WORDS (LINE_WORDS),
      .IDX_W      (IDX_W),
      .TAG_W      (TAG_W)
   ) u_array (
      .clk    (clk),
      .rst_n  (rst_n),
      .ridx   (idx),
      .rvalid (rvalid),
      .rtag   (rtag),
      .rline  (rline),
      .we     (fill_done),
      .widx   (miss_addr[OFF_W+IDX_W-1:OFF_W]),
      .wtag   (miss_addr[ADDR_W-1:OFF_W+IDX_W]),
      .wline  (mem_line)
   );

   // The fill always targets the latched miss address, even if i_addr moves meanwhile.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ICACHE_IDLE;
         miss_addr <= '0;
      end else if (state == ICACHE_IDLE) begin
         if (!hit) begin
            miss_addr <= {tag, idx, {OFF_W{1'b0}}};
            state     <= ICACHE_FILL;
         end
      end else if (mem_rdy) begin
         state <= ICACHE_IDLE;
      end
   end

   assign mem_req  = (state == ICACHE_FILL);
   assign mem_addr = miss_addr;
   assign i_rdy    = hit;

   always_comb begin
      instr = ICACHE_NOP;
      if (hit) begin
         instr = rline[16*off +: 16];
      end
   end

`ifdef ICACHE_PERF_CNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hit_cnt  <= '0;
         miss_cnt <= '0;
      end else begin
         if (hit && (hit_cnt != 16'hFFFF)) begin
            hit_cnt <= hit_cnt + 16'd1;
         end
         if ((state == ICACHE_IDLE) && !hit && (miss_cnt != 16'hFFFF)) begin
            miss_cnt <= miss_cnt + 16'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_icache.sv
// Directed self-checking bench for icache (SETS=8, LINE_WORDS=4, ADDR_W=16).
// Memory model: word at address a holds a ^ 16'hA000.
module tb_icache;

   logic        clk;
   logic        rst_n;
   logic [15:0] i_addr;
   logic [15:0] instr;
   logic        i_rdy;
   logic        mem_req;
   logic [15:0] mem_addr;
   logic        mem_rdy;
   logic [63:0] mem_line;
`ifdef ICACHE_PERF_CNT_EN
   logic [15:0] hit_cnt;
   logic [15:0] miss_cnt;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   icache #(.SETS(8), .LINE_WORDS(4), .ADDR_W(16)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_addr   (i_addr),
      .instr    (instr),
      .i_rdy    (i_rdy),
      .mem_req  (mem_req),
      .mem_addr (mem_addr),
      .mem_rdy  (mem_rdy),
      .mem_line (mem_line)
`ifdef ICACHE_PERF_CNT_EN
      ,
      .hit_cnt  (hit_cnt),
      .miss_cnt (miss_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [63:0] line_of(input logic [15:0] base);
      logic [63:0] l;
      for (int i = 0; i < 4; i++) begin
         l[16*i +: 16] = 16'(base + 16'(i)) ^ 16'hA000;
      end
      return l;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic hit(input string tag, input logic [15:0] a);
      i_addr = a;
      #1;
      check({tag, "_rdy"}, 32'(i_rdy), 32'd1);
      check({tag, "_instr"}, 32'(instr), 32'(a ^ 16'hA000));
      check({tag, "_req"}, 32'(mem_req), 32'd0);
      tick();
   endtask

   // Miss on a, mem_rdy returned in cycle k (k>=1), then the word must hit.
   task automatic do_fill(input string tag, input logic [15:0] a, input int k);
      logic [15:0] base;
      base   = {a[15:2], 2'b00};
      i_addr = a;
      #1;
      check({tag, "_miss"}, 32'(i_rdy), 32'd0);
      check({tag, "_miss_instr"}, 32'(instr), 32'd0);
      tick();
      check({tag, "_req"}, 32'(mem_req), 32'd1);
      check({tag, "_req_addr"}, 32'(mem_addr), 32'(base));
      repeat (k - 1) tick();
      check({tag, "_req_held"}, 32'(mem_req), 32'd1);
      mem_rdy  = 1'b1;
      mem_line = line_of(base);
      tick();
      mem_rdy  = 1'b0;
      mem_line = '0;
      #1;
      check({tag, "_fill_rdy"}, 32'(i_rdy), 32'd1);
      check({tag, "_fill_instr"}, 32'(instr), 32'(a ^ 16'hA000));
      check({tag, "_fill_req"}, 32'(mem_req), 32'd0);
   endtask

   initial begin
      rst_n    = 1'b0;
      i_addr   = 16'h0000;
      mem_rdy  = 1'b0;
      mem_line = '0;
      #1;
      check("rst_rdy", 32'(i_rdy), 32'd0);
      check("rst_instr", 32'(instr), 32'd0);
      check("rst_req", 32'(mem_req), 32'd0);
      check("rst_addr", 32'(mem_addr), 32'd0);
      tick();
      tick();
      rst_n = 1'b1;
      #1;
      check("post_rst_rdy", 32'(i_rdy), 32'd0);

      // Cold miss right after reset, fill returned in cycle 1.
      do_fill("t1", 16'h0000, 1);
      tick();

      // Cold miss with 3-cycle fill, then same-line hit without a request.
      do_fill("t2", 16'h0005, 3);
      tick();
      hit("t2_same", 16'h0006);
      hit("t2_same7", 16'h0007);

      // Conflict: 0x0020 shares idx 0 with 0x0000.
      do_fill("t3_conf", 16'h0020, 2);
      tick();
      do_fill("t3_back", 16'h0000, 1);
      tick();
      hit("t3_other", 16'h0004);

      // Stray mem_rdy while idle must not touch the arrays.
      i_addr   = 16'h0001;
      mem_rdy  = 1'b1;
      mem_line = {4{16'hDEAD}};
      tick();
      mem_rdy  = 1'b0;
      mem_line = '0;
      hit("t4_after", 16'h0001);
      hit("t4_other", 16'h0005);
      hit("t4_idx0", 16'h0003);

      // Top-of-memory line with an all-ones tag.
      do_fill("wrap", 16'hFFFD, 2);
      tick();
      hit("wrap_hit", 16'hFFFF);

      // Reset mid-fill: fill abandoned, late mem_rdy ignored, lines invalidated.
      i_addr = 16'h0008;
      tick();
      check("t5_req", 32'(mem_req), 32'd1);
      rst_n  = 1'b0;
      i_addr = 16'h0005;
      #1;
      check("t5_rst_req", 32'(mem_req), 32'd0);
      check("t5_rst_addr", 32'(mem_addr), 32'd0);
      check("t5_rst_rdy", 32'(i_rdy), 32'd0);
      tick();
      rst_n    = 1'b1;
      mem_rdy  = 1'b1;
      mem_line = line_of(16'h0008);
      #1;
      check("t5_late_rdy", 32'(i_rdy), 32'd0);
      tick();
      mem_rdy  = 1'b0;
      mem_line = '0;
      check("t5_rereq", 32'(mem_req), 32'd1);
      check("t5_rereq_addr", 32'(mem_addr), 32'h0004);
      mem_rdy  = 1'b1;
      mem_line = line_of(16'h0004);
      tick();
      mem_rdy  = 1'b0;
      mem_line = '0;
      check("t5_refill", 32'(instr), 32'(16'h0005 ^ 16'hA000));
      do_fill("t5_inval0", 16'h0000, 1);
      tick();

`ifdef ICACHE_PERF_CNT_EN
      rst_n = 1'b0;
      #1;
      check("cnt_rst_hit", 32'(hit_cnt), 32'd0);
      check("cnt_rst_miss", 32'(miss_cnt), 32'd0);
      tick();
      rst_n = 1'b1;
      do_fill("cnt", 16'h0040, 1);
      repeat (7) tick();
      check("cnt_hit7", 32'(hit_cnt), 32'd7);
      check("cnt_miss1", 32'(miss_cnt), 32'd1);
      repeat (70000) tick();
      check("cnt_hit_sat", 32'(hit_cnt), 32'hFFFF);
      check("cnt_miss_hold", 32'(miss_cnt), 32'd1);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
